// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies and HI/LO payload type.
// The D-stage decoder and stall unit use the same encodings.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU port bundle: forwarded operands and op in, stall and read result out.
interface e_mdu_if;
    logic [31:0] MDUIn1;
    logic [31:0] MDUIn2;
    logic [3:0]  MDUOp;
    logic        Req;
    logic        Busy;
    logic [31:0] MDURes;

    modport master (output MDUIn1, MDUIn2, MDUOp, Req, input Busy, MDURes);
    modport slave  (input MDUIn1, MDUIn2, MDUOp, Req, output Busy, MDURes);
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO; result computed at start,
// committed after a fixed latency so timing matches an iterative unit.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_r, start_c, commit_c, is_div_c;
    hilo_t           hilo_q, pend_q, pend_c;
    logic            pend_we_q, pend_we_c;

    logic [31:0]        a, b;
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] sa, sb;

    assign a     = bus.MDUIn1;
    assign b     = bus.MDUIn2;
    assign sa    = $signed(a);
    assign sb    = $signed(b);
    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load latency on start, count down, commit on reaching zero
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        is_div_c = (bus.MDUOp == MDU_DIV) || (bus.MDUOp == MDU_DIVU);
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_RUN;
                    cnt_d   = is_div_c ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = ST_IDLE;
                    commit_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: stall request and HI/LO read mux
    always_comb begin
        busy_r     = (state_q == ST_RUN);
        start_c    = 1'b0;
        bus.MDURes = '0;
        if ((bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU) ||
            (bus.MDUOp == MDU_DIV)  || (bus.MDUOp == MDU_DIVU))
            start_c = !bus.Req && !busy_r;
        bus.Busy = start_c || busy_r;
        case (bus.MDUOp)
            MDU_MFHI: bus.MDURes = hilo_q.hi;
            MDU_MFLO: bus.MDURes = hilo_q.lo;
            default:  bus.MDURes = '0;
        endcase
    end

    // Result computed up front; divide by zero leaves HI/LO untouched
    always_comb begin
        pend_c    = '0;
        pend_we_c = 1'b1;
        case (bus.MDUOp)
            MDU_MULT:  pend_c = hilo_t'(sprod);
            MDU_MULTU: pend_c = hilo_t'(uprod);
            MDU_DIV: begin
                if (b == 32'd0) begin
                    pend_we_c = 1'b0;
                end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
                    pend_c.lo = INT_MIN;
                    pend_c.hi = 32'd0;
                end else begin
                    pend_c.lo = 32'(sa / sb);
                    pend_c.hi = 32'(sa % sb);
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    pend_we_c = 1'b0;
                end else begin
                    pend_c.lo = a / b;
                    pend_c.hi = a % b;
                end
            end
            default: pend_we_c = 1'b0;
        endcase
    end

    // HI/LO and pending result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            hilo_q    <= '0;
            pend_q    <= '0;
            pend_we_q <= 1'b0;
        end else begin
            if (start_c) begin
                pend_q    <= pend_c;
                pend_we_q <= pend_we_c;
            end
            if (commit_c && pend_we_q)
                hilo_q <= pend_q;
            if (!busy_r && !bus.Req && bus.MDUOp == MDU_MTHI)
                hilo_q.hi <= a;
            if (!busy_r && !bus.Req && bus.MDUOp == MDU_MTLO)
                hilo_q.lo <= a;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus random traffic against a
// timeline model (start cycle + latency -> commit cycle) using 64-bit arithmetic.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic clk = 1'b0;
    logic reset;
    e_mdu_if mif ();

    e_mdu #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        p_we = 1'b0;
    int          cyc = 0, done_t = 0;
    logic        busy_obs;
    logic [31:0] res_obs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic is_md(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd4;
    endfunction

    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic we, output logic [31:0] h, output logic [31:0] l);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = longint'({32'd0, a});
        longint unsigned ub = longint'({32'd0, b});
        longint          sp, sq, sr;
        longint unsigned up, uq, ur;
        we = 1'b1; h = '0; l = '0;
        case (op)
            4'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            4'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            4'd3: if (b == 0) we = 1'b0;
                  else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            4'd4: if (b == 0) we = 1'b0;
                  else begin uq = ua / ub; ur = ua % ub; l = uq[31:0]; h = ur[31:0]; end
            default: we = 1'b0;
        endcase
    endfunction

    // One cycle: drive, check combinational outputs at negedge, advance model at posedge.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input logic rst);
        logic br, st, we;
        logic [31:0] er, h, l;
        mif.MDUOp = op; mif.MDUIn1 = a; mif.MDUIn2 = b; mif.Req = req; reset = rst;
        br = (cyc < done_t);
        st = is_md(op) && !req && !br;
        er = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        @(negedge clk);
        busy_obs = mif.Busy;
        res_obs  = mif.MDURes;
        check_val("busy", 32'(busy_obs), 32'(st | br));
        check_val("mdures", res_obs, er);
        @(posedge clk);
        #1;
        if (!rst) begin
            m_hi = '0; m_lo = '0; p_we = 1'b0; done_t = 0;
        end else begin
            if (br && cyc + 1 == done_t && p_we) begin m_hi = p_hi; m_lo = p_lo; end
            if (st) begin
                ref_op(op, a, b, we, h, l);
                p_we = we; p_hi = h; p_lo = l;
                done_t = cyc + 1 + ((op >= 4'd3) ? N_DIV : N_MULT);
            end else if (!br && !req && op == 4'd7) m_hi = a;
            else if (!br && !req && op == 4'd8) m_lo = a;
        end
        cyc++;
    endtask

    task automatic idle();
        step(4'd0, $urandom, $urandom, 1'b0, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles);
        int n;
        step(op, a, b, 1'b0, 1'b1);
        n = busy_obs ? 1 : 0;
        for (int i = 0; i < 40 && busy_obs; i++) begin
            idle();
            if (busy_obs) n++;
        end
        check_val(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic rd(input string tag, input logic [31:0] eh, input logic [31:0] el);
        step(4'd5, '0, '0, 1'b0, 1'b1);
        check_val({tag, "_hi"}, res_obs, eh);
        step(4'd6, '0, '0, 1'b0, 1'b1);
        check_val({tag, "_lo"}, res_obs, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        mif.MDUOp = 4'd0; mif.MDUIn1 = '0; mif.MDUIn2 = '0; mif.Req = 1'b0; reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle();
        check_val("reset_busy", 32'(busy_obs), 32'd0);
        rd("reset", 32'd0, 32'd0);

        run_op("mult_len", 4'd1, 32'hFFFF_FFFD, 32'd5, N_MULT + 1);
        rd("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_len", 4'd2, 32'hFFFF_FFFF, 32'd2, N_MULT + 1);
        rd("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_len", 4'd3, 32'hFFFF_FFF9, 32'd2, N_DIV + 1);
        rd("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0_len", 4'd4, 32'd7, 32'd0, N_DIV + 1);
        rd("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf_len", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, N_DIV + 1);
        rd("divovf", 32'd0, 32'h8000_0000);

        step(4'd7, 32'h1234_5678, '0, 1'b0, 1'b1);
        step(4'd5, '0, '0, 1'b0, 1'b1);
        check_val("mthi_mfhi", res_obs, 32'h1234_5678);
        step(4'd8, 32'hAAAA_5555, '0, 1'b1, 1'b1);
        rd("mtlo_req", 32'h1234_5678, 32'h8000_0000);

        step(4'd1, 32'd3, 32'd3, 1'b1, 1'b1);
        check_val("mult_req_busy", 32'(busy_obs), 32'd0);
        repeat (N_MULT + 1) idle();
        rd("mult_req", 32'h1234_5678, 32'h8000_0000);

        step(4'd1, 32'd6, 32'd7, 1'b0, 1'b1);
        idle();
        step(4'd0, '0, '0, 1'b1, 1'b1);
        repeat (N_MULT - 1) idle();
        check_val("late_req_busy", 32'(busy_obs), 32'd0);
        rd("late_req", 32'd0, 32'd42);

        step(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        idle();
        idle();
        step(4'd0, '0, '0, 1'b0, 1'b0);
        idle();
        check_val("rst_mid_busy", 32'(busy_obs), 32'd0);
        repeat (N_DIV + 2) idle();
        rd("rst_mid", 32'd0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            step(op, pick(), pick(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) != 0));
        end
        repeat (N_DIV + 2) idle();
        rd("final", m_hi, m_lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
